report_collector: RTL and testbench

- Sits directly downstream of the automata matcher `main`. Each cycle it samples the matcher's combinational `result` bit, qualified by the feeder's symbol-valid strobe.
- Tags every report with the index of the 16-bit character that produced it and buffers the tagged records in a FIFO for a host drain port with valid/ready handshake.
- Also keeps per-stream statistics (report count, dropped count) and marks end-of-stream, so the host can tell where one input file ends and the next begins.

---
 rtl/report_collector.sv | 143 ++++++++++++++
 tb/tb_report_collector.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/report_collector.sv
// Tags matcher reports with their character index and buffers them for a host
// drain port, keeping per-stream report/drop statistics.
module report_collector #(
    parameter int OFFSET_W = 32,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    input  logic                in_result,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OFFSET_W-1:0] out_offset,
    output logic                out_match,
    output logic                out_end,
    output logic [CNT_W-1:0]    report_count,
    output logic [CNT_W-1:0]    drop_count,
    output logic                overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [OFFSET_W-1:0] off_q   [DEPTH];
    logic [OFFSET_W-1:0] off_d   [DEPTH];
    logic                match_q [DEPTH];
    logic                match_d [DEPTH];
    logic                end_q   [DEPTH];
    logic                end_d   [DEPTH];

    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic [OFFSET_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]    rc_q, rc_d;
    logic [CNT_W-1:0]    dc_q, dc_d;
    logic                ov_q, ov_d;

    logic pop, push, accept, drop, stream_end;
    logic [PTR_W-1:0] newest_ptr;

    always_comb begin
        off_d    = off_q;
        match_d  = match_q;
        end_d    = end_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        idx_d    = idx_q;
        rc_d     = rc_q;
        dc_d     = dc_q;
        ov_d     = ov_q;

        pop        = (occ_q != '0) && out_ready;
        push       = in_valid && (in_result || in_last);
        accept     = push && ((occ_q != OCC_FULL) || pop);
        drop       = push && !accept;
        stream_end = in_valid && in_last;
        newest_ptr = wr_ptr_q - PTR_W'(1);

        if (accept) begin
            off_d[wr_ptr_q]   = idx_q;
            match_d[wr_ptr_q] = in_result;
            end_d[wr_ptr_q]   = in_last;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            if (in_result && (rc_q != '1)) begin
                rc_d = rc_q + CNT_W'(1);
            end
        end

        // A dropped end marker is folded into the newest stored record so
        // the host never loses a stream boundary.
        if (drop) begin
            if (dc_q != '1) begin
                dc_d = dc_q + CNT_W'(1);
            end
            ov_d = 1'b1;
            if (in_last) begin
                end_d[newest_ptr] = 1'b1;
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (accept && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!accept && pop) begin
            occ_d = occ_q - OCC_W'(1);
        end

        if (stream_end) begin
            idx_d = '0;
            rc_d  = '0;
            dc_d  = '0;
            ov_d  = 1'b0;
        end else if (in_valid) begin
            idx_d = idx_q + OFFSET_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                off_q[i]   <= '0;
                match_q[i] <= 1'b0;
                end_q[i]   <= 1'b0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            idx_q    <= '0;
            rc_q     <= '0;
            dc_q     <= '0;
            ov_q     <= 1'b0;
        end else begin
            off_q    <= off_d;
            match_q  <= match_d;
            end_q    <= end_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            idx_q    <= idx_d;
            rc_q     <= rc_d;
            dc_q     <= dc_d;
            ov_q     <= ov_d;
        end
    end

    // Head fields read as zero while empty so stale storage never leaks out.
    assign out_valid    = (occ_q != '0);
    assign out_offset   = out_valid ? off_q[rd_ptr_q]   : '0;
    assign out_match    = out_valid ? match_q[rd_ptr_q] : 1'b0;
    assign out_end      = out_valid ? end_q[rd_ptr_q]   : 1'b0;
    assign report_count = rc_q;
    assign drop_count   = dc_q;
    assign overflow     = ov_q;

endmodule

// File: tb/tb_report_collector.sv
// Bench for report_collector: constant vector table for a basic stream plus a
// queue scoreboard covering full-FIFO, boundary-overwrite and reset sequences.
module tb_report_collector;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_result, in_last;
    logic        out_valid, out_ready;
    logic [31:0] out_offset;
    logic        out_match, out_end;
    logic [15:0] report_count, drop_count;
    logic        overflow;

    report_collector #(.OFFSET_W(32), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_result(in_result), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_offset(out_offset), .out_match(out_match), .out_end(out_end),
        .report_count(report_count), .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] off;
        logic        m;
        logic        e;
    } rec_t;

    typedef struct {
        logic        v, r, l, rdy;
        logic        ev;
        logic [31:0] eoff;
        logic        em, ee;
        logic [15:0] erc;
    } vec_t;

    rec_t        sb[$];
    logic [31:0] m_idx;
    logic [15:0] m_rc, m_dc;
    logic        m_ov;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        m_idx = '0;
        m_rc  = '0;
        m_dc  = '0;
        m_ov  = 1'b0;
    endtask

    task automatic drive(input logic v, input logic r, input logic l, input logic rdy);
        in_valid  = v;
        in_result = r;
        in_last   = l;
        out_ready = rdy;
    endtask

    task automatic check_sb();
        chk("sb_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("sb_offset", 64'(out_offset), 64'(sb[0].off));
            chk("sb_match",  64'(out_match),  64'(sb[0].m));
            chk("sb_end",    64'(out_end),    64'(sb[0].e));
        end
        chk("sb_report_count", 64'(report_count), 64'(m_rc));
        chk("sb_drop_count",   64'(drop_count),   64'(m_dc));
        chk("sb_overflow",     64'(overflow),     64'(m_ov));
    endtask

    // Applies the current cycle's inputs to the reference queue, then moves
    // to just after the next rising edge.
    task automatic advance();
        logic pop, push, acc;
        rec_t rec;
        pop  = (sb.size() != 0) && out_ready;
        push = in_valid && (in_result || in_last);
        acc  = push && ((sb.size() < DEPTH) || pop);
        if (pop) void'(sb.pop_front());
        if (acc) begin
            rec.off = m_idx;
            rec.m   = in_result;
            rec.e   = in_last;
            sb.push_back(rec);
            if (in_result && m_rc != 16'hFFFF) m_rc++;
        end else if (push) begin
            if (m_dc != 16'hFFFF) m_dc++;
            m_ov = 1'b1;
            if (in_last) sb[sb.size()-1].e = 1'b1;
        end
        if (in_valid && in_last) begin
            m_idx = '0;
            m_rc  = '0;
            m_dc  = '0;
            m_ov  = 1'b0;
        end else if (in_valid) begin
            m_idx++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic step(input logic v, input logic r, input logic l, input logic rdy);
        drive(v, r, l, rdy);
        @(negedge clock);
        check_sb();
        advance();
    endtask

    vec_t tbl[11];

    initial begin
        // Stream of indices 0..9: reports at 3 and 7, last at 9, host always ready.
        //            v  r  l rdy ev eoff em ee erc
        tbl[0]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 1, 0, 1, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 0, 0, 1, 1, 3, 1, 0, 1};
        tbl[5]  = '{1, 0, 0, 1, 0, 0, 0, 0, 1};
        tbl[6]  = '{1, 0, 0, 1, 0, 0, 0, 0, 1};
        tbl[7]  = '{1, 1, 0, 1, 0, 0, 0, 0, 1};
        tbl[8]  = '{1, 0, 0, 1, 1, 7, 1, 0, 2};
        tbl[9]  = '{1, 0, 1, 1, 0, 0, 0, 0, 2};
        tbl[10] = '{0, 0, 0, 1, 1, 9, 0, 1, 0};

        reset_n = 1'b0;
        drive(0, 0, 0, 0);
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_valid", 64'(out_valid), 64'(0));
        chk("reset_offset", 64'(out_offset), 64'(0));
        chk("reset_counts", 64'({report_count, drop_count, overflow}), 64'(0));
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].r, tbl[i].l, tbl[i].rdy);
            @(negedge clock);
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_offset", i), 64'(out_offset), 64'(tbl[i].eoff));
            chk($sformatf("tbl%0d_match", i), 64'(out_match), 64'(tbl[i].em));
            chk($sformatf("tbl%0d_end", i), 64'(out_end), 64'(tbl[i].ee));
            chk($sformatf("tbl%0d_rc", i), 64'(report_count), 64'(tbl[i].erc));
            check_sb();
            advance();
        end

        // One-character stream with result and last together.
        step(1, 1, 1, 1);
        drive(0, 0, 0, 1);
        @(negedge clock);
        chk("single_rec", 64'({out_valid, out_offset, out_match, out_end}),
            64'({1'b1, 32'd0, 1'b1, 1'b1}));
        check_sb();
        advance();

        // Fill with 20 reports while the host stalls.
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0);
        drive(0, 0, 0, 0);
        @(negedge clock);
        chk("full_drop_count", 64'(drop_count), 64'(4));
        chk("full_overflow", 64'(overflow), 64'(1));
        chk("full_head", 64'(out_offset), 64'(0));
        check_sb();
        advance();

        // Full FIFO, push and pop together: accepted, no extra drop.
        step(1, 1, 0, 1);
        drive(0, 0, 0, 0);
        @(negedge clock);
        chk("fullpp_drop_count", 64'(drop_count), 64'(4));
        chk("fullpp_head", 64'(out_offset), 64'(1));
        chk("fullpp_depth", 64'(sb.size()), 64'(DEPTH));
        check_sb();
        advance();

        // Still full; plain characters up to index 39, then last at 40 is dropped.
        for (int i = 21; i < 40; i++) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        drive(0, 0, 0, 0);
        @(negedge clock);
        chk("bound_overflow_clr", 64'(overflow), 64'(0));
        chk("bound_drop_clr", 64'(drop_count), 64'(0));
        check_sb();
        advance();

        // Drain; the new stream's first report lands while draining.
        step(1, 1, 0, 1);
        for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 1);
        chk("drained", 64'(sb.size()), 64'(0));

        // Reset with five records held mid-stream.
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
        drive(0, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_counts", 64'({report_count, drop_count, overflow}), 64'(0));
        model_clear();
        #1;
        reset_n = 1'b1;
        step(1, 1, 0, 0);
        drive(0, 0, 0, 1);
        @(negedge clock);
        chk("postrst_offset", 64'({out_valid, out_offset}), 64'({1'b1, 32'd0}));
        check_sb();
        advance();
        step(0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
